// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: drives a 4-bit ALU nibble by nibble (LSN first) to build a WIDTH-bit result; ALU_SEQ_OVF_FLAG_EN enables out_ovf.
module alu_nibble_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_sel,
  output logic             alu_m,
  output logic             alu_cin,
  input  logic [3:0]       alu_sum,
  input  logic [3:0]       alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err,
  output logic             out_ovf
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic c_q, c_d, err_q, err_d;
  logic [IW-1:0] i_q, i_d;
  logic [1:0] sel_q, sel_d;
  logic arith, last, unused_cout;
  assign arith = op_q < 3'd2;
  assign last = i_q == IW'(NIB - 1);
  assign unused_cout = ^alu_cout[2:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      c_q <= 1'b0;
      err_q <= 1'b0;
      i_q <= '0;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      c_q <= c_d;
      err_q <= err_d;
      i_q <= i_d;
      sel_q <= sel_d;
    end
  end
  // Operands shift right each nibble so the ALU always sees bits [3:0]; they drain to zero by DONE.
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    c_d = c_q;
    err_d = err_q;
    i_d = i_q;
    sel_d = sel_q;
    case (state_q)
      IDLE: if (in_valid) begin
        op_d = in_op;
        err_d = in_op > 3'd4;
        a_d = err_d ? '0 : in_a;
        b_d = err_d ? '0 : (in_op == 3'd1 ? ~in_b : in_b);
        res_d = '0;
        c_d = in_op == 3'd1;
        i_d = '0;
        sel_d = in_op == 3'd2 ? 2'd1 : in_op == 3'd3 ? 2'd2 : in_op == 3'd4 ? 2'd3 : 2'd0;
        state_d = err_d ? DONE : EXEC;
      end
      EXEC: begin
        res_d = WIDTH'({alu_sum, res_q} >> 4);
        a_d = a_q >> 4;
        b_d = b_q >> 4;
        i_d = i_q + IW'(1);
        c_d = arith ? (a_q[3] & b_q[3]) | ((a_q[3] ^ b_q[3]) & alu_cout[3]) : 1'b0;
        if (last) begin
          state_d = DONE;
          sel_d = 2'd0;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign alu_a = a_q[3:0];
  assign alu_b = b_q[3:0];
  assign alu_sel = sel_q;
  assign alu_m = 1'b0;
  assign alu_cin = (state_q == EXEC) & c_q;
  assign out_res = res_q;
  assign out_carry = out_valid & arith & c_q;
  assign out_zero = out_valid & ~|res_q;
  assign out_err = out_valid & err_q;
`ifdef ALU_SEQ_OVF_FLAG_EN
  logic sa_q, sb_q;
  // sb_q holds the sign of the operand actually added (already inverted for SUB).
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      sa_q <= in_a[WIDTH-1];
      sb_q <= in_op == 3'd1 ? ~in_b[WIDTH-1] : in_b[WIDTH-1];
    end
  end
  assign out_ovf = out_valid & arith & ~err_q & (sa_q == sb_q) & (res_q[WIDTH-1] != sa_q);
`else
  assign out_ovf = 1'b0;
`endif
endmodule
